// File: rtl/serial_slot_sequencer.sv
// Bus-mapped serial shifter: decodes a slot/subaddress command on the rising
// edge of the access strobe and clocks a WIDTH-bit word out on sdo/sclk.
//
// state | meaning
// IDLE  | waiting for START; sdo=0, sclk=0
// LOW   | sclk low half-period; current bit presented on sdo
// HIGH  | sclk high half-period; sdi sampled on entry
// DONE  | one clk: done pulse, received word published
module serial_slot_sequencer #(
  parameter int         WIDTH     = 6,
  parameter int         DIV_W     = 4,
  parameter bit         LSB_FIRST = 1'b0,
  parameter logic [1:0] SLOT      = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sser_n,
  input  logic [1:0]       ba_hi,
  input  logic [3:0]       ba_sub,
  input  logic             br_w,
  input  logic [WIDTH-1:0] bd,
  input  logic             sdi,
  output logic             sdo,
  output logic             sclk,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int DW_MIN = (DIV_W < WIDTH) ? DIV_W : WIDTH;
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [DIV_W-1:0] PRE_ONE = DIV_W'(1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t           state_q, state_d;
  logic             acc, acc_q, exec;
  logic             cmd_load, cmd_start, cmd_div, cmd_abort;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] sh_q, sh_d, sh_nxt;
  logic [WIDTH-1:0] rxsh_q, rxsh_d, rxsh_nxt;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [DIV_W-1:0] div_q, div_d, div_wr;
  logic [DIV_W-1:0] pre_q, pre_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sdo_q, sdo_d;
  logic             half_end;

  assign acc  = ~sser_n & (ba_hi == SLOT) & br_w;
  assign exec = acc & ~acc_q;

  assign cmd_load  = exec && (ba_sub == 4'h0);
  assign cmd_start = exec && (ba_sub == 4'h1);
  assign cmd_div   = exec && (ba_sub == 4'h2);
  assign cmd_abort = exec && (ba_sub == 4'h3);

  assign half_end = (pre_q == '0);

  assign sh_nxt   = LSB_FIRST ? {1'b0, sh_q[WIDTH-1:1]} : {sh_q[WIDTH-2:0], 1'b0};
  assign rxsh_nxt = LSB_FIRST ? {sdi, rxsh_q[WIDTH-1:1]} : {rxsh_q[WIDTH-2:0], sdi};

  // The prescaler field may be wider than the data bus; upper bits read as 0.
  always_comb begin
    div_wr = '0;
    div_wr[DW_MIN-1:0] = bd[DW_MIN-1:0];
  end

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    sh_d    = sh_q;
    rxsh_d  = rxsh_q;
    rx_d    = rx_q;
    div_d   = div_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    sdo_d   = sdo_q;

    if (state_q == IDLE) begin
      if (cmd_load) tx_d = bd;
      if (cmd_div)  div_d = div_wr;
    end

    case (state_q)
      IDLE: begin
        if (cmd_start) begin
          state_d = LOW;
          sh_d    = tx_q;
          cnt_d   = CNT_INIT;
          pre_d   = div_q;
          sdo_d   = LSB_FIRST ? tx_q[0] : tx_q[WIDTH-1];
        end
      end
      LOW: begin
        if (half_end) begin
          state_d = HIGH;
          pre_d   = div_q;
          rxsh_d  = rxsh_nxt;
        end else begin
          pre_d = pre_q - PRE_ONE;
        end
      end
      HIGH: begin
        if (half_end) begin
          if (cnt_q == CNT_ONE) begin
            state_d = DONE;
            sdo_d   = 1'b0;
            rx_d    = rxsh_q;
          end else begin
            state_d = LOW;
            pre_d   = div_q;
            cnt_d   = cnt_q - CNT_ONE;
            sh_d    = sh_nxt;
            sdo_d   = LSB_FIRST ? sh_nxt[0] : sh_nxt[WIDTH-1];
          end
        end else begin
          pre_d = pre_q - PRE_ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over everything, including a word completing this same clk.
    if (cmd_abort) begin
      state_d = IDLE;
      sdo_d   = 1'b0;
      rx_d    = rx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= 1'b0;
      tx_q    <= '0;
      sh_q    <= '0;
      rxsh_q  <= '0;
      rx_q    <= '0;
      div_q   <= '0;
      pre_q   <= '0;
      cnt_q   <= '0;
      sdo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc;
      tx_q    <= tx_d;
      sh_q    <= sh_d;
      rxsh_q  <= rxsh_d;
      rx_q    <= rx_d;
      div_q   <= div_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      sdo_q   <= sdo_d;
    end
  end

  assign sdo     = sdo_q;
  assign sclk    = (state_q == HIGH);
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign rx_data = rx_q;

endmodule
